// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low keypad column scanner with key latch, release qualification and two-digit history.
//   clk          system clock
//   reset        asynchronous active-low reset
//   rows[3:0]    keypad rows, active-low, asynchronous to clk
//   cols[3:0]    keypad columns, one-hot-low, registered
//   key_code     hex code of the latched key
//   key_pressed  live level of the latched key's row
//   new_key      one-cycle pulse on each latch
//   digit_new    most recent key code
//   digit_old    previous key code
module keypad_scanner #(
  parameter int SCAN_DIV      = 4,
  parameter int RELEASE_TICKS = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] rows,
  output logic [3:0] cols,
  output logic [3:0] key_code,
  output logic       key_pressed,
  output logic       new_key,
  output logic [3:0] digit_new,
  output logic [3:0] digit_old
);
  localparam int CW = $clog2(SCAN_DIV);
  localparam int RW = $clog2(RELEASE_TICKS + 1);
  // nibble {row, col} holds the legend of that key
  localparam logic [63:0] KEY_MAP = 64'hDF0E_C987_B654_A321;
  typedef enum logic {SCAN, HOLD} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] rel_q, rel_d;
  logic [3:0]    rows_m_q, rows_s_q;
  logic [3:0]    cols_q, cols_d;
  logic [1:0]    row_q, row_d;
  logic [3:0]    key_code_q, key_code_d;
  logic          key_pressed_q, key_pressed_d;
  logic          new_key_q, new_key_d;
  logic [3:0]    digit_new_q, digit_new_d;
  logic [3:0]    digit_old_q, digit_old_d;
  logic          tick, one_low, row_high, released;
  logic [3:0]    low, cols_rot, new_code;
  logic [1:0]    hit_row, col_idx;
  assign tick     = cnt_q == CW'(SCAN_DIV - 1);
  assign low      = ~rows_s_q;
  // exactly one row low; two or more is a ghost and is ignored
  assign one_low  = (low != 4'd0) && ((low & (low - 4'd1)) == 4'd0);
  assign hit_row  = low[0] ? 2'd0 : low[1] ? 2'd1 : low[2] ? 2'd2 : 2'd3;
  assign col_idx  = !cols_q[0] ? 2'd0 : !cols_q[1] ? 2'd1 : !cols_q[2] ? 2'd2 : 2'd3;
  assign new_code = KEY_MAP[{hit_row, col_idx, 2'b00} +: 4];
  assign cols_rot = {cols_q[2:0], cols_q[3]};
  assign row_high = rows_s_q[row_q];
  assign released = tick && row_high && rel_q == RW'(RELEASE_TICKS - 1);
  always_comb begin
    state_d       = state_q;
    cnt_d         = tick ? '0 : cnt_q + 1'b1;
    rel_d         = rel_q;
    cols_d        = cols_q;
    row_d         = row_q;
    key_code_d    = key_code_q;
    key_pressed_d = key_pressed_q;
    new_key_d     = 1'b0;
    digit_new_d   = digit_new_q;
    digit_old_d   = digit_old_q;
    if (state_q == SCAN) begin
      if (tick && one_low) begin
        state_d       = HOLD;
        row_d         = hit_row;
        key_code_d    = new_code;
        key_pressed_d = 1'b1;
        new_key_d     = 1'b1;
        digit_old_d   = digit_new_q;
        digit_new_d   = new_code;
      end else if (tick) begin
        cols_d = cols_rot;
      end
    end else begin
      key_pressed_d = !row_high;
      // release completion wins over detection; next detect is on a later tick
      if (released) begin
        state_d = SCAN;
        rel_d   = '0;
        cols_d  = cols_rot;
      end else if (tick) begin
        rel_d = row_high ? rel_q + 1'b1 : '0;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= SCAN;
      cnt_q         <= '0;
      rel_q         <= '0;
      rows_m_q      <= 4'b1111;
      rows_s_q      <= 4'b1111;
      cols_q        <= 4'b1110;
      row_q         <= 2'd0;
      key_code_q    <= 4'd0;
      key_pressed_q <= 1'b0;
      new_key_q     <= 1'b0;
      digit_new_q   <= 4'd0;
      digit_old_q   <= 4'd0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rel_q         <= rel_d;
      rows_m_q      <= rows;
      rows_s_q      <= rows_m_q;
      cols_q        <= cols_d;
      row_q         <= row_d;
      key_code_q    <= key_code_d;
      key_pressed_q <= key_pressed_d;
      new_key_q     <= new_key_d;
      digit_new_q   <= digit_new_d;
      digit_old_q   <= digit_old_d;
    end
  end
  assign cols        = cols_q;
  assign key_code    = key_code_q;
  assign key_pressed = key_pressed_q;
  assign new_key     = new_key_q;
  assign digit_new   = digit_new_q;
  assign digit_old   = digit_old_q;
endmodule
